// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port external memory arbiter.
// Imported by the interface, the winner-select logic and the top level.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;
    localparam int LAT_W    = 3;
    // Wide enough for STARVE_MAX up to 15
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the memory port arbiter.
// Handshake: REQn is held with WEn/LOCKn/ADDRn/WDATn stable until GNTn pulses for one cycle.
// That pulse means the access was issued; a dropped REQn before GNTn withdraws it.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              REQ0;
    logic              WE0;
    logic              LOCK0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] WDAT0;
    logic              GNT0;
    logic              RVALID0;
    logic [DATA_W-1:0] RDAT0;

    logic              REQ1;
    logic              WE1;
    logic              LOCK1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDAT1;
    logic              GNT1;
    logic              RVALID1;
    logic [DATA_W-1:0] RDAT1;

    logic [ADDR_W-1:0] MADDR;
    logic [DATA_W-1:0] MWDAT;
    logic              MWE;
    logic              MRE;
    logic [DATA_W-1:0] MRDAT;
    logic              BUSY;

    state_e            dbg_state;
    logic [STARVE_W-1:0] dbg_starve;

    modport slave (
        input  REQ0, WE0, LOCK0, ADDR0, WDAT0,
        input  REQ1, WE1, LOCK1, ADDR1, WDAT1,
        input  MRDAT,
        output GNT0, RVALID0, RDAT0,
        output GNT1, RVALID1, RDAT1,
        output MADDR, MWDAT, MWE, MRE, BUSY,
        output dbg_state, dbg_starve
    );

    modport master (
        output REQ0, WE0, LOCK0, ADDR0, WDAT0,
        output REQ1, WE1, LOCK1, ADDR1, WDAT1,
        output MRDAT,
        input  GNT0, RVALID0, RDAT0,
        input  GNT1, RVALID1, RDAT1,
        input  MADDR, MWDAT, MWE, MRE, BUSY,
        input  dbg_state, dbg_starve
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for two requesters: lock, then starvation, then priority/round-robin.
module arb_pick2
    import mem_arb_pkg::*;
#(
    parameter int CPU_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic [1:0]          req,
    input  logic                lock,
    input  logic                lock_port,
    input  logic                rr_last,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                win_valid,
    output logic                win_port
);

    always_comb begin
        win_valid = 1'b0;
        win_port  = 1'(PORT_CPU);
        if (lock && req[lock_port]) begin
            win_valid = 1'b1;
            win_port  = lock_port;
        end else if (req == 2'b11) begin
            // A lock whose owner has gone quiet falls through to normal arbitration
            win_valid = 1'b1;
            if (starve_cnt == STARVE_W'(STARVE_MAX))
                win_port = 1'(PORT_AUX);
            else if (CPU_PRIO != 0)
                win_port = 1'(PORT_CPU);
            else
                win_port = ~rr_last;
        end else if (req[PORT_CPU]) begin
            win_valid = 1'b1;
            win_port  = 1'(PORT_CPU);
        end else if (req[PORT_AUX]) begin
            win_valid = 1'b1;
            win_port  = 1'(PORT_AUX);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered external memory port between the CPU path (port 0) and an auxiliary master (port 1).
// Each access: arbitration, registered issue, then a fixed read latency before data return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int CPU_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               CLK,
    input logic               RSTN,
    mem_port_arbiter_if.slave bus
);

    state_e              state, state_nxt;
    logic [LAT_W-1:0]    cnt, cnt_nxt;
    logic                lock_q, lock_nxt;
    logic                lock_port, lock_port_nxt;
    logic                rr_last, rr_nxt;
    logic [STARVE_W-1:0] starve_cnt, starve_nxt;
    logic                rd_port, rd_port_nxt;
    logic [ADDR_W-1:0]   maddr_q, maddr_nxt;
    logic [DATA_W-1:0]   mwdat_q, mwdat_nxt;
    logic                mwe_q, mwe_nxt;
    logic                mre_q, mre_nxt;
    logic [1:0]          gnt_q, gnt_nxt;
    logic [1:0]          rvalid_q, rvalid_nxt;
    logic [DATA_W-1:0]   rdat0_q, rdat0_nxt;
    logic [DATA_W-1:0]   rdat1_q, rdat1_nxt;

    logic [1:0] req;
    logic       win_valid;
    logic       win_port;
    logic       sample;
    logic       we_w;
    logic       lock_w;

    assign req = {bus.REQ1, bus.REQ0};
    // The request is still held during its grant cycle, so arbitration skips that cycle
    assign sample = (state == IDLE) && (gnt_q == 2'b00);
    assign we_w   = win_port ? bus.WE1   : bus.WE0;
    assign lock_w = win_port ? bus.LOCK1 : bus.LOCK0;

    arb_pick2 #(
        .CPU_PRIO   (CPU_PRIO),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .req        (req),
        .lock       (lock_q),
        .lock_port  (lock_port),
        .rr_last    (rr_last),
        .starve_cnt (starve_cnt),
        .win_valid  (win_valid),
        .win_port   (win_port)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            cnt        <= '0;
            lock_q     <= 1'b0;
            lock_port  <= 1'b0;
            rr_last    <= 1'b1;
            starve_cnt <= '0;
            rd_port    <= 1'b0;
            maddr_q    <= '0;
            mwdat_q    <= '0;
            mwe_q      <= 1'b0;
            mre_q      <= 1'b0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdat0_q    <= '0;
            rdat1_q    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lock_q     <= lock_nxt;
            lock_port  <= lock_port_nxt;
            rr_last    <= rr_nxt;
            starve_cnt <= starve_nxt;
            rd_port    <= rd_port_nxt;
            maddr_q    <= maddr_nxt;
            mwdat_q    <= mwdat_nxt;
            mwe_q      <= mwe_nxt;
            mre_q      <= mre_nxt;
            gnt_q      <= gnt_nxt;
            rvalid_q   <= rvalid_nxt;
            rdat0_q    <= rdat0_nxt;
            rdat1_q    <= rdat1_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lock_nxt      = lock_q;
        lock_port_nxt = lock_port;
        rr_nxt        = rr_last;
        starve_nxt    = starve_cnt;
        rd_port_nxt   = rd_port;
        maddr_nxt     = maddr_q;
        mwdat_nxt     = mwdat_q;
        mwe_nxt       = 1'b0;
        mre_nxt       = 1'b0;
        gnt_nxt       = 2'b00;
        rvalid_nxt    = 2'b00;
        rdat0_nxt     = rdat0_q;
        rdat1_nxt     = rdat1_q;

        case (state)
            IDLE: begin
                if (sample) begin
                    if (lock_q && !req[lock_port])
                        lock_nxt = 1'b0;
                    if (win_valid) begin
                        gnt_nxt[win_port] = 1'b1;
                        maddr_nxt         = win_port ? bus.ADDR1 : bus.ADDR0;
                        mwdat_nxt         = win_port ? bus.WDAT1 : bus.WDAT0;
                        mwe_nxt           = we_w;
                        mre_nxt           = ~we_w;
                        rr_nxt            = win_port;
                        lock_nxt          = lock_w;
                        lock_port_nxt     = win_port;
                        if (!we_w) begin
                            state_nxt   = RD_WAIT;
                            cnt_nxt     = LAT_W'(MEM_LAT - 1);
                            rd_port_nxt = win_port;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    rvalid_nxt[rd_port] = 1'b1;
                    if (rd_port)
                        rdat1_nxt = bus.MRDAT;
                    else
                        rdat0_nxt = bus.MRDAT;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Counts only real arbitration losses; an idle port 1 is never starving
        if (!bus.REQ1)
            starve_nxt = '0;
        else if (sample && win_valid) begin
            if (win_port)
                starve_nxt = '0;
            else if (starve_cnt != STARVE_W'(STARVE_MAX))
                starve_nxt = starve_cnt + 1'b1;
        end
    end

    assign bus.GNT0       = gnt_q[0];
    assign bus.GNT1       = gnt_q[1];
    assign bus.RVALID0    = rvalid_q[0];
    assign bus.RVALID1    = rvalid_q[1];
    assign bus.RDAT0      = rdat0_q;
    assign bus.RDAT1      = rdat1_q;
    assign bus.MADDR      = maddr_q;
    assign bus.MWDAT      = mwdat_q;
    assign bus.MWE        = mwe_q;
    assign bus.MRE        = mre_q;
    assign bus.BUSY       = (state != IDLE) || lock_q;
    assign bus.dbg_state  = state;
    assign bus.dbg_starve = starve_cnt;

endmodule
